master_cmd_loader: RTL
======================

# master_cmd_loader

Command queue feeding the radar timing master. Accepts host commands as an 11-word 32-bit stream, assembles each into one pulse-train command and buffers up to DEPTH commands in a FIFO. Presents the head command on the master's MEM_* inputs with a one-cycle WR_DATA strobe when the master requests a new command. The first command after reset or flush is loaded without a request. Single clock domain, 48 MHz, same clock as the master.

## Interface
- DEPTH, 4: FIFO depth in commands, 2..16.
- CLK  in  1  system clock, 48 MHz.
- RESET  in  1  asynchronous, active-high reset.
- IN_VALID  in  1  input word valid.
- IN_SOP  in  1  marks word 0 of a command; qualified by IN_VALID.
- IN_DATA  in  32  command word.
- IN_READY  out  1  word accepted on a cycle where IN_VALID&&IN_READY; equals (level!=DEPTH).
- FLUSH  in  1  synchronous clear of FIFO and partial assembly.
- REQ_COMMAND  in  1  master's end-of-command flag (level); only its rising edge is used.
- WR_DATA  out  1  one-cycle load strobe to master.
- MEM_DDS_freq  out  48  start frequency.
- MEM_DDS_delta_freq  out  48  frequency step.
- MEM_DDS_delta_rate  out  32  frequency step rate.
- MEM_TIME_START  out  48  start time.
- MEM_N_impuls  out  16  pulse count.
- MEM_TYPE_impulse  out  2  0 = incoherent, 1 = coherent.
- MEM_Interval_Ti, MEM_Interval_Tp, MEM_Tblank1, MEM_Tblank2  out  32 each  interval lengths in 1/48 µs.
- FIFO_LEVEL  out  5  number of stored commands, 0..DEPTH.
- FRAME_ERR  out  1  one-cycle pulse on a framing error.
- STARVED  out  1  pending && level==0.

## Operation
- Word map, one accepted word per index:
  - w0 freq[31:0]
  - w1 [15:0] freq[47:32], [31:16] N_impuls
  - w2 dfreq[31:0]
  - w3 [15:0] dfreq[47:32], [17:16] TYPE; other bits ignored
  - w4 rate
  - w5 time[31:0]
  - w6 [15:0] time[47:32]; other bits ignored
  - w7 Ti, w8 Tp, w9 Tblank1, w10 Tblank2
- Word counter wcnt, 0..10:
  - An accepted word with IN_SOP=1 is always stored as w0 and sets wcnt=1.
  - If wcnt was not 0 at that point, FRAME_ERR pulses and the partial command is discarded.
  - A word accepted with wcnt==0 and IN_SOP=0 is dropped and FRAME_ERR pulses.
- Push: when w10 is accepted, the assembled command (w0..w9 registers plus IN_DATA) is written to the FIFO at that same edge, and wcnt returns to 0.
- pending flag:
  - Set to 1 by reset and by FLUSH.
  - Set on a REQ_COMMAND rising edge (REQ_COMMAND=1 with the previous sample 0).
  - Cleared when a pop occurs.
- Pop: when pending && level>0, the FIFO head is registered onto MEM_*, WR_DATA=1 for one cycle, and level decrements.
- A REQ_COMMAND edge while pending is already 1 is absorbed; requests do not accumulate.
- MEM_* hold their value between pops.
- FLUSH:
  - Empties the FIFO, sets wcnt=0 and pending=1.
  - Leaves MEM_* unchanged.
  - Wins over a same-cycle push or pop; no WR_DATA is issued that cycle.

## Timing
- Reset values:
  - MEM_TIME_START = 48'hFFFFFFFFFFFF (never matches master time).
  - All other MEM_* = 0.
  - WR_DATA=0, FRAME_ERR=0, FIFO_LEVEL=0, IN_READY=1, STARVED=1.
- Push at edge k: FIFO_LEVEL increments at edge k.
- Pop:
  - Earliest pop is edge k+1 after a push at edge k.
  - WR_DATA and the new MEM_* appear at the same edge, and WR_DATA falls one cycle later.
- REQ_COMMAND latency: rising edge first sampled at edge e sets pending at e. With level>0, the pop is at e+1.
- Simultaneous push and pop: level is unchanged.
- IN_READY depends only on the registered level. At level==DEPTH it stays 0 even in a pop cycle and rises the cycle after.
- Reset asserted mid-command: assembly, FIFO and outputs return to reset values immediately (asynchronous).

## Test plan
- Reset, then stream one command (freq=48'h0000_1234_5678, N=3, Ti=100). Required: WR_DATA pulses exactly once, one cycle after w10 is accepted; MEM_DDS_freq=48'h0000_1234_5678, MEM_N_impuls=3, MEM_Interval_Ti=100; FIFO_LEVEL returns to 0.
- Load commands A, B, C with no REQ_COMMAND rise after A has been issued. Required: only A is issued, FIFO_LEVEL=2. Raise REQ_COMMAND: B is issued one cycle after pending sets. Hold REQ_COMMAND high: C is not issued until REQ_COMMAND falls and rises again.
- DEPTH=4, host keeps IN_VALID=1 with no requests. Required: IN_READY=0 once FIFO_LEVEL=4. One REQ_COMMAND rise: pop, then IN_READY=1 on the following cycle.
- IN_SOP asserted at wcnt=5 of command A. Required: FRAME_ERR pulses once; A is discarded; the following full command is issued with correct fields.
- FIFO empty, REQ_COMMAND rises. Required: STARVED=1. Then push a command: WR_DATA at the edge after the push, STARVED=0.
- FLUSH in the same cycle as a w10 accept with FIFO_LEVEL=2. Required: FIFO_LEVEL=0, no WR_DATA, MEM_* unchanged. The next complete command is issued without a REQ_COMMAND rise.

Source files
------------

// File: rtl/master_cmd_loader.sv
// Command queue for the radar timing master: assembles 11-word host commands,
// buffers them in a FIFO and hands the head command over on request.
module master_cmd_loader #(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IN_VALID,
  input  logic        IN_SOP,
  input  logic [31:0] IN_DATA,
  output logic        IN_READY,
  input  logic        FLUSH,
  input  logic        REQ_COMMAND,
  output logic        WR_DATA,
  output logic [47:0] MEM_DDS_freq,
  output logic [47:0] MEM_DDS_delta_freq,
  output logic [31:0] MEM_DDS_delta_rate,
  output logic [47:0] MEM_TIME_START,
  output logic [15:0] MEM_N_impuls,
  output logic [1:0]  MEM_TYPE_impulse,
  output logic [31:0] MEM_Interval_Ti,
  output logic [31:0] MEM_Interval_Tp,
  output logic [31:0] MEM_Tblank1,
  output logic [31:0] MEM_Tblank2,
  output logic [4:0]  FIFO_LEVEL,
  output logic        FRAME_ERR,
  output logic        STARVED
);

  localparam int         AW        = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
  localparam logic [3:0] LAST_WORD = 4'd10;

  // Fields collected from words 0..9; word 10 (Tblank2) goes straight from IN_DATA.
  typedef struct packed {
    logic [47:0] freq;
    logic [15:0] n_impuls;
    logic [47:0] dfreq;
    logic [1:0]  typ;
    logic [31:0] rate;
    logic [47:0] tstart;
    logic [31:0] ti;
    logic [31:0] tp;
    logic [31:0] tblank1;
  } hdr_t;

  typedef struct packed {
    hdr_t        hdr;
    logic [31:0] tblank2;
  } cmd_t;

  logic [3:0]    wcnt;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          pending;
  logic          req_prev;
  hdr_t          asm_hdr;
  cmd_t          mem [DEPTH];
  cmd_t          head_cmd;
  logic          accept;
  logic          push;
  logic          pop;
  logic          req_rise;
  logic          frame_err_d;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
    return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign IN_READY    = (FIFO_LEVEL != 5'(DEPTH));
  assign STARVED     = pending && (FIFO_LEVEL == 5'd0);
  assign accept      = IN_VALID && IN_READY;
  assign push        = accept && !IN_SOP && (wcnt == LAST_WORD) && !FLUSH;
  assign pop         = pending && (FIFO_LEVEL != 5'd0) && !FLUSH;
  assign req_rise    = REQ_COMMAND && !req_prev;
  assign frame_err_d = accept && !FLUSH && (IN_SOP ? (wcnt != 4'd0) : (wcnt == 4'd0));
  assign head_cmd    = mem[head];

  // NOTE: payload storage carries no reset; wcnt and the FIFO pointers decide validity.
  always_ff @(posedge CLK) begin
    if (accept && !FLUSH) begin
      if (IN_SOP) begin
        asm_hdr.freq[31:0] <= IN_DATA;
      end else begin
        case (wcnt)
          4'd1: begin
            asm_hdr.freq[47:32] <= IN_DATA[15:0];
            asm_hdr.n_impuls    <= IN_DATA[31:16];
          end
          4'd2: asm_hdr.dfreq[31:0] <= IN_DATA;
          4'd3: begin
            asm_hdr.dfreq[47:32] <= IN_DATA[15:0];
            asm_hdr.typ          <= IN_DATA[17:16];
          end
          4'd4:    asm_hdr.rate          <= IN_DATA;
          4'd5:    asm_hdr.tstart[31:0]  <= IN_DATA;
          4'd6:    asm_hdr.tstart[47:32] <= IN_DATA[15:0];
          4'd7:    asm_hdr.ti            <= IN_DATA;
          4'd8:    asm_hdr.tp            <= IN_DATA;
          4'd9:    asm_hdr.tblank1       <= IN_DATA;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[tail] <= '{hdr: asm_hdr, tblank2: IN_DATA};
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wcnt               <= 4'd0;
      head               <= '0;
      tail               <= '0;
      FIFO_LEVEL         <= 5'd0;
      pending            <= 1'b1;
      req_prev           <= 1'b0;
      WR_DATA            <= 1'b0;
      FRAME_ERR          <= 1'b0;
      MEM_DDS_freq       <= '0;
      MEM_DDS_delta_freq <= '0;
      MEM_DDS_delta_rate <= '0;
      MEM_TIME_START     <= '1;
      MEM_N_impuls       <= '0;
      MEM_TYPE_impulse   <= '0;
      MEM_Interval_Ti    <= '0;
      MEM_Interval_Tp    <= '0;
      MEM_Tblank1        <= '0;
      MEM_Tblank2        <= '0;
    end else begin
      req_prev  <= REQ_COMMAND;
      WR_DATA   <= pop;
      FRAME_ERR <= frame_err_d;

      if (FLUSH) begin
        wcnt <= 4'd0;
      end else if (accept) begin
        if (IN_SOP)                                   wcnt <= 4'd1;
        else if (wcnt == 4'd0 || wcnt == LAST_WORD)   wcnt <= 4'd0;
        else                                          wcnt <= wcnt + 4'd1;
      end

      if (FLUSH) begin
        head       <= '0;
        tail       <= '0;
        FIFO_LEVEL <= 5'd0;
      end else begin
        if (push) tail <= next_ptr(tail);
        if (pop)  head <= next_ptr(head);
        if (push && !pop)      FIFO_LEVEL <= FIFO_LEVEL + 5'd1;
        else if (pop && !push) FIFO_LEVEL <= FIFO_LEVEL - 5'd1;
      end

      // A request edge while already pending is absorbed; requests never queue up.
      if (FLUSH)         pending <= 1'b1;
      else if (pop)      pending <= 1'b0;
      else if (req_rise) pending <= 1'b1;

      if (pop) begin
        MEM_DDS_freq       <= head_cmd.hdr.freq;
        MEM_DDS_delta_freq <= head_cmd.hdr.dfreq;
        MEM_DDS_delta_rate <= head_cmd.hdr.rate;
        MEM_TIME_START     <= head_cmd.hdr.tstart;
        MEM_N_impuls       <= head_cmd.hdr.n_impuls;
        MEM_TYPE_impulse   <= head_cmd.hdr.typ;
        MEM_Interval_Ti    <= head_cmd.hdr.ti;
        MEM_Interval_Tp    <= head_cmd.hdr.tp;
        MEM_Tblank1        <= head_cmd.hdr.tblank1;
        MEM_Tblank2        <= head_cmd.tblank2;
      end
    end
  end

endmodule
